mult_div: RTL and testbench

- Iterative multiply/divide unit (HI/LO) for the MIPS datapath.
- Sits alongside the ALU, downstream of the register file read ports (rs/rt operands).
- Executes MULT, MULTU, DIV and DIVU in 33 cycles and holds results in HI/LO.
- The control unit stalls the PC while busy is high; MFHI/MFLO read hi/lo directly; MTHI/MTLO write through hi_we/lo_we.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/abs_neg32.sv | 26 ++
 rtl/mult_div.sv | 212 +++++++++++++++++++++
 tb/tb_mult_div.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit (mult_div).
//   - op_e    : 2-bit operation code (MULT, MULTU, DIV, DIVU)
//   - state_e : FSM states (IDLE, CALC, FINISH)
//   - ITER_COUNT / CNT_W : number of shift iterations and the counter width
package mdu_pkg;

   localparam int ITER_COUNT = 32;
   localparam int CNT_W      = 5;

   // Bit 1 selects divide, bit 0 selects the unsigned flavour.
   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_CALC   = 2'b01,
      S_FINISH = 2'b10
   } state_e;

endpackage

// File: rtl/abs_neg32.sv
// abs_neg32
// Conditional two's-complement negate. Used to turn signed operands into
// magnitudes at start and to restore the result sign when an operation finishes.
// Ports:
//   value_i  : input value
//   neg_i    : 1 = negate, 0 = pass through
//   result_o : value_i or -value_i
// A magnitude of -2^31 comes out as 32'h80000000, which is correct when the
// result is treated as unsigned.
module abs_neg32 #(
   parameter int W = 32
) (
   input  logic [W-1:0] value_i,
   input  logic         neg_i,
   output logic [W-1:0] result_o
);

   // Pure combinational negate; no state in this block.
   always_comb begin
      result_o = value_i;
      if (neg_i) begin
         result_o = ~value_i + W'(1);
      end
   end

endmodule

// File: rtl/mult_div.sv
// mult_div
// Iterative HI/LO multiply/divide unit for the MIPS datapath. MULT, MULTU, DIV
// and DIVU take 33 cycles after the start edge; HI/LO are also writable
// directly through MTHI/MTLO while the unit is idle.
// Ports:
//   clk, reset    : rising-edge clock, asynchronous active-high reset
//   start, op     : begin operation op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   a, b          : rs / rt operands
//   hi_we, lo_we  : MTHI / MTLO write enables, data on wdata
//   busy          : operation in progress (PC stall)
//   done          : one-cycle pulse after HI/LO were written by an operation
//   hi, lo        : HI and LO registers
module mult_div
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   op_e                op_q;
   logic [WIDTH-1:0]   aOrig_q;
   logic [WIDTH-1:0]   divisor_q;
   logic               negRes_q;
   logic               negRem_q;
   logic               divZero_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               busy_q;
   logic               done_q;

   logic               signedIn;
   logic               negA;
   logic               negB;
   logic [WIDTH-1:0]   magA;
   logic [WIDTH-1:0]   magB;
   logic               isDiv;
   logic [WIDTH:0]     mulSum;
   logic [WIDTH:0]     divShift;
   logic [WIDTH-1:0]   divDiff;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   quotFix;
   logic [WIDTH-1:0]   remFix;

   // Operand preparation: signed ops work on magnitudes and remember the signs.
   always_comb begin
      signedIn = ~op[0];
      negA     = signedIn & a[WIDTH-1];
      negB     = signedIn & b[WIDTH-1];
   end

   abs_neg32 #(.W(WIDTH)) uAbsA (
      .value_i  (a),
      .neg_i    (negA),
      .result_o (magA)
   );

   abs_neg32 #(.W(WIDTH)) uAbsB (
      .value_i  (b),
      .neg_i    (negB),
      .result_o (magB)
   );

   // One iteration step. Both algorithms share the 64-bit accumulator:
   // multiply keeps {partial product, remaining multiplier bits} and shifts
   // right; divide keeps {partial remainder, dividend/quotient bits} and
   // shifts left. The remainder is always below the divisor, so the
   // subtraction result fits in WIDTH bits and the 33rd bit is only needed
   // for the compare.
   always_comb begin
      isDiv    = (op_q == OP_DIV) || (op_q == OP_DIVU);
      mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, divisor_q};
      divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      divDiff  = divShift[WIDTH-1:0] - divisor_q;
      acc_d    = acc_q;
      if (!isDiv) begin
         if (acc_q[0]) begin
            acc_d = {mulSum, acc_q[WIDTH-1:1]};
         end else begin
            acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
         end
      end else begin
         if (divShift >= {1'b0, divisor_q}) begin
            acc_d = {divDiff, acc_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_d = {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Sign fixup for the final result. The product needs a full 64-bit negate,
   // quotient and remainder are fixed independently.
   always_comb begin
      product = acc_q;
      if (negRes_q) begin
         product = ~acc_q + (2*WIDTH)'(1);
      end
   end

   abs_neg32 #(.W(WIDTH)) uFixQuot (
      .value_i  (acc_q[WIDTH-1:0]),
      .neg_i    (negRes_q),
      .result_o (quotFix)
   );

   abs_neg32 #(.W(WIDTH)) uFixRem (
      .value_i  (acc_q[2*WIDTH-1:WIDTH]),
      .neg_i    (negRem_q),
      .result_o (remFix)
   );

   // Main FSM. IDLE accepts MTHI/MTLO writes and start, CALC runs the 32
   // iterations without touching HI/LO, FINISH writes the fixed-up result and
   // raises done for exactly one cycle. A start arriving outside IDLE is simply
   // dropped. Divide by zero bypasses the datapath result: HI gets the original
   // dividend and LO all ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_q      <= OP_MULT;
         aOrig_q   <= '0;
         divisor_q <= '0;
         negRes_q  <= 1'b0;
         negRem_q  <= 1'b0;
         divZero_q <= 1'b0;
         acc_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (hi_we) begin
                  hi_q <= wdata;
               end
               if (lo_we) begin
                  lo_q <= wdata;
               end
               if (start) begin
                  op_q      <= op_e'(op);
                  aOrig_q   <= a;
                  divisor_q <= magB;
                  negRes_q  <= negA ^ negB;
                  negRem_q  <= negA;
                  divZero_q <= (b == '0);
                  acc_q     <= {{WIDTH{1'b0}}, magA};
                  cnt_q     <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= S_CALC;
               end
            end
            S_CALC: begin
               acc_q <= acc_d;
               if (cnt_q == LAST_ITER) begin
                  state_q <= S_FINISH;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_FINISH: begin
               if (isDiv) begin
                  if (divZero_q) begin
                     hi_q <= aOrig_q;
                     lo_q <= '1;
                  end else begin
                     hi_q <= remFix;
                     lo_q <= quotFix;
                  end
               end else begin
                  hi_q <= product[2*WIDTH-1:WIDTH];
                  lo_q <= product[WIDTH-1:0];
               end
               cnt_q   <= '0;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div
// Directed bench for mult_div: each task drives one scenario and compares the
// observed HI/LO/busy/done against hand-computed values.
module tb_mult_div;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int vectors;
   int miscompares;

   mult_div #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 ns past it before sampling/driving.
   task automatic stepEdge();
      @(posedge clk);
      #1;
   endtask

   // Pulses start for one edge (edge k) and follows the operation up to and
   // including edge k+33. Returns how many samples saw busy, how many saw an
   // early done, and how often HI/LO changed while the operation ran.
   task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x,
                                input logic [31:0] y, output int busyCycles,
                                output int earlyDone, output int hiLoMoved);
      logic [31:0] hiRef;
      logic [31:0] loRef;
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      stepEdge();
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      hiRef = hi;
      loRef = lo;
      busyCycles = 0;
      earlyDone  = 0;
      hiLoMoved  = 0;
      for (int i = 0; i < 33; i++) begin
         if (busy) busyCycles++;
         if (done) earlyDone++;
         if (hi !== hiRef || lo !== loRef) hiLoMoved++;
         stepEdge();
      end
   endtask

   task automatic test_reset();
      vectors++;
      if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_state: hi=%h lo=%h busy=%b done=%b, want all zero",
                  hi, lo, busy, done);
      end
   endtask

   task automatic test_multu_max();
      int bc, ed, mv;
      applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, ed, mv);
      vectors++;
      if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
         miscompares++;
         $display("[TB] FAIL multu_max: got %h_%h, want fffffffe_00000001", hi, lo);
      end
      vectors++;
      if (bc != 33 || ed != 0 || mv != 0 || done !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL multu_timing: busy=%0d early_done=%0d moved=%0d done=%b busy_end=%b, want 33/0/0/1/0",
                  bc, ed, mv, done, busy);
      end
      stepEdge();
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL done_pulse_width: done=%b one cycle later, want 0", done);
      end
   endtask

   task automatic test_signed();
      int bc, ed, mv;
      applyStimulus(2'b00, 32'hFFFFFFFD, 32'd7, bc, ed, mv);
      vectors++;
      if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
         miscompares++;
         $display("[TB] FAIL mult_neg: got %h_%h, want ffffffff_ffffffeb", hi, lo);
      end
      stepEdge();
      applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2, bc, ed, mv);
      vectors++;
      if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
         miscompares++;
         $display("[TB] FAIL div_neg: lo=%h hi=%h, want lo=fffffffd hi=ffffffff", lo, hi);
      end
      stepEdge();
      applyStimulus(2'b00, 32'h80000000, 32'h80000000, bc, ed, mv);
      vectors++;
      if (hi !== 32'h40000000 || lo !== 32'h00000000) begin
         miscompares++;
         $display("[TB] FAIL mult_minint: got %h_%h, want 40000000_00000000", hi, lo);
      end
      stepEdge();
   endtask

   task automatic test_div_boundary();
      int bc, ed, mv;
      applyStimulus(2'b11, 32'd100, 32'd0, bc, ed, mv);
      vectors++;
      if (hi !== 32'd100 || lo !== 32'hFFFFFFFF || bc != 33) begin
         miscompares++;
         $display("[TB] FAIL divu_by_zero: hi=%h lo=%h busy=%0d, want 64/ffffffff/33", hi, lo, bc);
      end
      stepEdge();
      applyStimulus(2'b10, 32'hFFFFFFF9, 32'd0, bc, ed, mv);
      vectors++;
      if (hi !== 32'hFFFFFFF9 || lo !== 32'hFFFFFFFF) begin
         miscompares++;
         $display("[TB] FAIL div_by_zero_neg: hi=%h lo=%h, want fffffff9/ffffffff", hi, lo);
      end
      stepEdge();
      applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, bc, ed, mv);
      vectors++;
      if (lo !== 32'h80000000 || hi !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL div_minint_m1: lo=%h hi=%h, want 80000000/0", lo, hi);
      end
      stepEdge();
      applyStimulus(2'b10, 32'd7, 32'hFFFFFFFE, bc, ed, mv);
      vectors++;
      if (lo !== 32'hFFFFFFFD || hi !== 32'd1) begin
         miscompares++;
         $display("[TB] FAIL div_pos_by_neg: lo=%h hi=%h, want fffffffd/1", lo, hi);
      end
      stepEdge();
   endtask

   task automatic test_back_to_back();
      int bc, ed, mv;
      int doneSeen;
      op    = 2'b11;
      a     = 32'd100;
      b     = 32'd7;
      start = 1'b1;
      stepEdge();
      start    = 1'b0;
      doneSeen = 0;
      for (int i = 1; i <= 32; i++) begin
         if (i == 5) begin
            start = 1'b1;
            op    = 2'b01;
            a     = 32'd50;
            b     = 32'd3;
         end
         if (i == 8) start = 1'b0;
         stepEdge();
         if (done) doneSeen++;
      end
      stepEdge();
      vectors++;
      if (lo !== 32'd14 || hi !== 32'd2 || done !== 1'b1 || doneSeen != 0) begin
         miscompares++;
         $display("[TB] FAIL busy_start_ignored: lo=%0d hi=%0d done=%b early=%0d, want 14/2/1/0",
                  lo, hi, done, doneSeen);
      end
      applyStimulus(2'b01, 32'd6, 32'd7, bc, ed, mv);
      vectors++;
      if (lo !== 32'd42 || hi !== 32'd0 || bc != 33) begin
         miscompares++;
         $display("[TB] FAIL back_to_back: lo=%0d hi=%0d busy=%0d, want 42/0/33", lo, hi, bc);
      end
      stepEdge();
   endtask

   task automatic test_mthi_mtlo();
      logic [31:0] loBefore;
      int          bc, ed, mv;
      loBefore = lo;
      hi_we    = 1'b1;
      wdata    = 32'h1234;
      stepEdge();
      hi_we = 1'b0;
      vectors++;
      if (hi !== 32'h1234 || lo !== loBefore) begin
         miscompares++;
         $display("[TB] FAIL mthi_idle: hi=%h lo=%h, want 1234/%h", hi, lo, loBefore);
      end
      lo_we = 1'b1;
      wdata = 32'hBEEF;
      stepEdge();
      lo_we = 1'b0;
      vectors++;
      if (lo !== 32'hBEEF || hi !== 32'h1234) begin
         miscompares++;
         $display("[TB] FAIL mtlo_idle: lo=%h hi=%h, want beef/1234", lo, hi);
      end
      op    = 2'b01;
      a     = 32'd3;
      b     = 32'd4;
      start = 1'b1;
      stepEdge();
      start = 1'b0;
      stepEdge();
      lo_we = 1'b1;
      hi_we = 1'b1;
      wdata = 32'hDEAD;
      stepEdge();
      lo_we = 1'b0;
      hi_we = 1'b0;
      vectors++;
      if (lo !== 32'hBEEF || hi !== 32'h1234) begin
         miscompares++;
         $display("[TB] FAIL mtlo_busy: lo=%h hi=%h, want beef/1234", lo, hi);
      end
      for (int i = 0; i < 31; i++) stepEdge();
      vectors++;
      if (lo !== 32'd12 || hi !== 32'd0 || done !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL mult_after_mt: lo=%0d hi=%0d done=%b, want 12/0/1", lo, hi, done);
      end
      stepEdge();
      op    = 2'b01;
      a     = 32'd5;
      b     = 32'd5;
      lo_we = 1'b1;
      wdata = 32'hABCD;
      start = 1'b1;
      stepEdge();
      start = 1'b0;
      lo_we = 1'b0;
      vectors++;
      if (lo !== 32'hABCD || busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL start_with_mtlo: lo=%h busy=%b, want abcd/1", lo, busy);
      end
      for (int i = 0; i < 33; i++) stepEdge();
      vectors++;
      if (lo !== 32'd25 || hi !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL start_with_mtlo_result: lo=%0d hi=%0d, want 25/0", lo, hi);
      end
      stepEdge();
   endtask

   task automatic test_reset_midop();
      int bc, ed, mv;
      int doneSeen;
      hi_we = 1'b1;
      wdata = 32'h55;
      stepEdge();
      hi_we = 1'b0;
      op    = 2'b01;
      a     = 32'hFFFFFFFF;
      b     = 32'd3;
      start = 1'b1;
      stepEdge();
      start = 1'b0;
      for (int i = 0; i < 10; i++) stepEdge();
      reset = 1'b1;
      #1;
      vectors++;
      if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL async_reset: hi=%h lo=%h busy=%b done=%b, want 0/0/0/0",
                  hi, lo, busy, done);
      end
      stepEdge();
      reset    = 1'b0;
      doneSeen = 0;
      for (int i = 0; i < 40; i++) begin
         stepEdge();
         if (done || busy) doneSeen++;
      end
      vectors++;
      if (doneSeen != 0) begin
         miscompares++;
         $display("[TB] FAIL no_done_after_reset: %0d active cycles, want 0", doneSeen);
      end
      applyStimulus(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, ed, mv);
      vectors++;
      if (hi !== 32'h0 || lo !== 32'd1 || bc != 33) begin
         miscompares++;
         $display("[TB] FAIL fresh_after_reset: %h_%h busy=%0d, want 00000000_00000001/33", hi, lo, bc);
      end
   endtask

   // Scenario sequence; every task leaves the bench 1 ns past an edge.
   initial begin
      vectors     = 0;
      miscompares = 0;
      reset = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      wdata = '0;
      #12;
      test_reset();
      stepEdge();
      reset = 1'b0;
      stepEdge();
      test_reset();
      test_multu_max();
      test_signed();
      test_div_boundary();
      test_back_to_back();
      test_mthi_mtlo();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
